elevator_scheduler: RTL
=======================

Name: elevator_scheduler

Overview:
- Car-level controller for the elevator. Latches floor calls, chooses the travel direction by SCAN (keep going while calls remain ahead, otherwise reverse), steps the car floor by floor, and sequences door open/hold/close.
- Paced by a 1-cycle tick enable from the existing divider chain.
- Drives move_handler, the pulse the door-timing logic uses to restart its count.

Parameters:
- NUM_FLOORS, 8, number of floors; must be ≥ 2.
- FLOOR_W, 3, width of the floor index; must satisfy 2**FLOOR_W ≥ NUM_FLOORS.
- TRAVEL_TICKS, 4, ticks to travel one floor; must be ≥ 1.
- DOOR_TICKS, 2, ticks the door stays open; must be ≥ 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  single-cycle time-base enable.
- call_req  input  NUM_FLOORS  level call buttons; bit i = floor i.
- weight_limit_exceeded  input  1  high = hold the door open and do not depart.
- current_floor  output  FLOOR_W  last floor reached or currently served.
- moving_up  output  1  motor up command.
- moving_down  output  1  motor down command.
- door_open  output  1  door open command.
- pending  output  NUM_FLOORS  latched outstanding calls.
- move_handler  output  1  1-cycle pulse on every entry to MOVING.

Behaviour:
- Reset: state=IDLE, current_floor=0, dir=UP, pending=0, counters=0. All outputs 0, except current_floor which is also 0 by definition.
- Request latch:
  - pending <= (pending | call_req) & ~clear each cycle.
  - clear is the current_floor bit when the car is serving that floor (entering or in DOOR_OPEN).
  - A call at the served floor while in DOOR_OPEN is never latched.
- States:
  - IDLE: motor and door off.
    - If pending[current_floor] is set: go to DOOR_OPEN next cycle and clear that bit.
    - Else if calls exist ahead in dir: go to MOVING.
    - Else if calls exist behind: flip dir, then go to MOVING in the same transition.
    - Else stay in IDLE.
  - MOVING: moving_up = (dir==UP), moving_down = (dir==DN).
    - Count ticks; on the TRAVEL_TICKS-th tick, current_floor steps ±1 on the next edge.
    - If the new floor is pending: go to DOOR_OPEN and clear its bit. Otherwise stay in MOVING with the counter reset. move_handler does not re-pulse.
  - DOOR_OPEN: door_open=1. Count ticks.
    - While weight_limit_exceeded is high, or a call_req arrives for current_floor, the count resets to 0.
    - On the DOOR_TICKS-th tick with weight_limit_exceeded low: go to IDLE. door_open falls on the same edge.
- move_handler: registered; high for exactly the first cycle in which state==MOVING.
- Ticks: counted only in the state that consumes them. A tick on a transition cycle is not carried over. Tick counters are wide enough for the parameter value and never wrap.
- Bounds:
  - current_floor never goes below 0 or above NUM_FLOORS-1.
  - dir is forced to DN at the top floor and UP at floor 0 when choosing.
  - No departure from IDLE is possible while weight_limit_exceeded is high. IDLE stays put in that case, even with calls pending.
- Simultaneous events:
  - Calls ahead and behind in IDLE: dir wins.
  - A call for the floor just left, during MOVING: latched and served after reversal.
- Reset mid-move or mid-door: immediate return to reset values. Pending calls are lost.
- Motor and door exclusivity: moving_* and door_open are never high together; a checker asserts this.

Optional Feature:
- Macro: ELEVATOR_CLOSE_BTN_EN.
- Defined:
  - Adds input door_close_btn (1 bit).
  - In DOOR_OPEN, door_close_btn=1 with weight_limit_exceeded=0 goes to IDLE on the next edge, without waiting for the tick count.
  - weight_limit_exceeded=1 overrides the button.
- Undefined: the port does not exist and the door closes on tick count only.

Decomposition:
- Package elevator_pkg holds:
  - state enum {IDLE, MOVING, DOOR_OPEN};
  - dir typedef {UP, DN};
  - default constants for NUM_FLOORS, TRAVEL_TICKS and DOOR_TICKS.
- Sub-module elevator_req_scan (combinational): from pending and current_floor, produces any_above and any_below.

Test Plan (NUM_FLOORS=8, TRAVEL_TICKS=4, DOOR_TICKS=2, tick every 4 clk):
- Reset, then pulse call_req=8'h08 → move_handler pulses once. moving_up stays high for 12 ticks and current_floor steps 1, 2, 3. Then door_open=1 for 2 ticks, then IDLE, with pending=0.
- At floor 3 in IDLE, set call_req=8'h01 and 8'h80 together (dir=UP) → serves 7 first, reverses, serves 0. move_handler pulses twice in total.
- weight_limit_exceeded=1 throughout DOOR_OPEN at floor 2 → door_open stays 1 for 20 ticks. Drop it → closes 2 ticks later.
- call_req=8'h04 at floor 2 while the door is open → hold count restarts and pending[2] stays 0.
- Assert rst during MOVING between floors 4 and 5 → all outputs go to 0 asynchronously and current_floor=0.
- With ELEVATOR_CLOSE_BTN_EN: door_close_btn=1 in the first cycle of DOOR_OPEN → IDLE next cycle. Repeat with weight_limit_exceeded=1 → no effect.

Source files
------------

// File: rtl/elevator_scheduler_pkg.sv
// elevator_pkg: shared types and default sizing for the elevator car controller.
// Also provides the tick-counter width helper used by the scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

    typedef enum logic {UP, DN} dir_t;

    localparam int DEF_NUM_FLOORS   = 8;
    localparam int DEF_FLOOR_W      = 3;
    localparam int DEF_TRAVEL_TICKS = 4;
    localparam int DEF_DOOR_TICKS   = 2;

    // Bits needed to hold any count from 0 up to max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: call/weight/tick inputs and car status outputs of the
// elevator scheduler. master = the surrounding system, slave = the scheduler.
// Optional macro ELEVATOR_CLOSE_BTN_EN adds the door_close_btn signal.
interface elevator_scheduler_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
);
    logic                  tick;
    logic [NUM_FLOORS-1:0] call_req;
    logic                  weight_limit_exceeded;
`ifdef ELEVATOR_CLOSE_BTN_EN
    logic                  door_close_btn;
`endif
    logic [FLOOR_W-1:0]    current_floor;
    logic                  moving_up;
    logic                  moving_down;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;
    logic                  move_handler;

    modport master (
        output tick, call_req, weight_limit_exceeded,
`ifdef ELEVATOR_CLOSE_BTN_EN
        output door_close_btn,
`endif
        input  current_floor, moving_up, moving_down, door_open, pending, move_handler
    );

    modport slave (
        input  tick, call_req, weight_limit_exceeded,
`ifdef ELEVATOR_CLOSE_BTN_EN
        input  door_close_btn,
`endif
        output current_floor, moving_up, moving_down, door_open, pending, move_handler
    );

endinterface

// File: rtl/elevator_scheduler_req_scan.sv
// elevator_req_scan: reports whether any latched call lies above or below the
// car's current floor, feeding the SCAN direction choice.
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  any_above,
    output logic                  any_below
);

    // Reduce the pending calls on each side of the car to a single flag.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(current_floor)) any_above = any_above | pending[i];
            if (i < int'(current_floor)) any_below = any_below | pending[i];
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: car-level SCAN controller. Latches floor calls, keeps
// travelling while calls remain ahead, reverses otherwise, steps one floor per
// TRAVEL_TICKS ticks and holds the door open for DOOR_TICKS ticks.
// Optional macro ELEVATOR_CLOSE_BTN_EN: door_close_btn ends the door hold early.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
    parameter int FLOOR_W      = DEF_FLOOR_W,
    parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int DOOR_TICKS   = DEF_DOOR_TICKS
) (
    input logic clk,
    input logic rst,
    elevator_scheduler_if.slave bus
);

    localparam int TW = cnt_width(TRAVEL_TICKS);
    localparam int DW = cnt_width(DOOR_TICKS);
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    state_t                state;
    dir_t                  dir;
    logic [FLOOR_W-1:0]    floor_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [TW-1:0]         travel_cnt;
    logic [DW-1:0]         door_cnt;
    logic                  move_handler_q;
    logic                  moving_up_q;
    logic                  moving_down_q;
    logic                  door_open_q;

    logic                  any_above;
    logic                  any_below;
    logic [FLOOR_W-1:0]    next_floor;
    logic [NUM_FLOORS-1:0] floor_onehot;
    logic [NUM_FLOORS-1:0] next_onehot;
    logic [NUM_FLOORS-1:0] latched;
    dir_t                  choose_dir;
    dir_t                  go_dir;
    logic                  ahead;
    logic                  behind;
    logic                  door_hold;
    logic                  close_now;

    elevator_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending       (pending_q),
        .current_floor (floor_q),
        .any_above     (any_above),
        .any_below     (any_below)
    );

    // Next-floor, SCAN direction choice and door-hold conditions for the FSM.
    always_comb begin
        floor_onehot = NUM_FLOORS'(1) << floor_q;
        if (dir == UP) next_floor = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FLOOR_W'(1);
        else           next_floor = (floor_q == '0) ? floor_q : floor_q - FLOOR_W'(1);
        next_onehot = NUM_FLOORS'(1) << next_floor;
        if (floor_q == TOP_FLOOR) choose_dir = DN;
        else if (floor_q == '0)   choose_dir = UP;
        else                      choose_dir = dir;
        ahead     = (choose_dir == UP) ? any_above : any_below;
        behind    = (choose_dir == UP) ? any_below : any_above;
        go_dir    = ahead ? choose_dir : ((choose_dir == UP) ? DN : UP);
        door_hold = bus.weight_limit_exceeded | bus.call_req[floor_q];
        latched   = pending_q | bus.call_req;
`ifdef ELEVATOR_CLOSE_BTN_EN
        close_now = bus.door_close_btn & ~bus.weight_limit_exceeded;
`else
        close_now = 1'b0;
`endif
    end

    // Car FSM with request latch, tick counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            dir            <= UP;
            floor_q        <= '0;
            pending_q      <= '0;
            travel_cnt     <= '0;
            door_cnt       <= '0;
            move_handler_q <= 1'b0;
            moving_up_q    <= 1'b0;
            moving_down_q  <= 1'b0;
            door_open_q    <= 1'b0;
        end else begin
            move_handler_q <= 1'b0;
            pending_q      <= latched;
            case (state)
                IDLE: begin
                    if (!bus.weight_limit_exceeded) begin
                        if (pending_q[floor_q]) begin
                            state       <= DOOR_OPEN;
                            door_cnt    <= '0;
                            door_open_q <= 1'b1;
                            pending_q   <= latched & ~floor_onehot;
                        end else if (ahead || behind) begin
                            state          <= MOVING;
                            dir            <= go_dir;
                            travel_cnt     <= '0;
                            move_handler_q <= 1'b1;
                            moving_up_q    <= (go_dir == UP);
                            moving_down_q  <= (go_dir == DN);
                        end
                    end
                end
                MOVING: begin
                    if (bus.tick) begin
                        if (travel_cnt == TRAVEL_LAST) begin
                            travel_cnt <= '0;
                            floor_q    <= next_floor;
                            if (pending_q[next_floor]) begin
                                state         <= DOOR_OPEN;
                                door_cnt      <= '0;
                                moving_up_q   <= 1'b0;
                                moving_down_q <= 1'b0;
                                door_open_q   <= 1'b1;
                                pending_q     <= latched & ~next_onehot;
                            end
                        end else begin
                            travel_cnt <= travel_cnt + TW'(1);
                        end
                    end
                end
                DOOR_OPEN: begin
                    pending_q <= latched & ~floor_onehot;
                    if (close_now) begin
                        state       <= IDLE;
                        door_cnt    <= '0;
                        door_open_q <= 1'b0;
                    end else if (door_hold) begin
                        door_cnt <= '0;
                    end else if (bus.tick) begin
                        if (door_cnt == DOOR_LAST) begin
                            state       <= IDLE;
                            door_cnt    <= '0;
                            door_open_q <= 1'b0;
                        end else begin
                            door_cnt <= door_cnt + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Motor and door are never commanded at the same time.
    assert property (@(posedge clk) disable iff (rst)
        !((moving_up_q || moving_down_q) && door_open_q));

    assign bus.current_floor = floor_q;
    assign bus.moving_up     = moving_up_q;
    assign bus.moving_down   = moving_down_q;
    assign bus.door_open     = door_open_q;
    assign bus.pending       = pending_q;
    assign bus.move_handler  = move_handler_q;

endmodule
